// File: rtl/board_engine_pkg.sv
// Shared types and helpers for the playfield engine: FSM states, command codes,
// rotation-0 piece masks and the clockwise mask rotation.
// Pure declarations, no logic; optional DROP state exists only with BOARD_ENGINE_HARD_DROP_EN.
package board_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_ACTIVE,
        S_LAND,
        S_CLEAR,
        S_GAMEOVER
`ifdef BOARD_ENGINE_HARD_DROP_EN
        , S_DROP
`endif
    } state_t;

    localparam logic [1:0] CMD_LEFT   = 2'd0;
    localparam logic [1:0] CMD_RIGHT  = 2'd1;
    localparam logic [1:0] CMD_ROTATE = 2'd2;
    localparam logic [1:0] CMD_DOWN   = 2'd3;

    // 2x2 masks, bit i = dy*2+dx
    localparam logic [3:0] MASK_T0 = 4'b0001;
    localparam logic [3:0] MASK_T1 = 4'b0011;
    localparam logic [3:0] MASK_T2 = 4'b0111;
    localparam logic [3:0] MASK_T3 = 4'b1111;

    // Clockwise: bit 0->1, 1->3, 3->2, 2->0
    function automatic logic [3:0] rotate_cw(input logic [3:0] m);
        return {m[1], m[3], m[0], m[2]};
    endfunction

    function automatic logic [3:0] piece_mask(input logic [1:0] t, input logic [1:0] r);
        logic [3:0] m;
        case (t)
            2'd0:    m = MASK_T0;
            2'd1:    m = MASK_T1;
            2'd2:    m = MASK_T2;
            default: m = MASK_T3;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (i < int'(r)) m = rotate_cw(m);
        end
        return m;
    endfunction

endpackage

// File: rtl/board_collide.sv
// Collision check of a 2x2 piece mask placed at signed (x, y) against the locked board.
// Latency: purely combinational. Backpressure: none.
// Ports: board (locked cells), mask, x, y (signed, may be off-board) -> hit.
module board_collide
    import board_engine_pkg::*;
#(
    parameter int W  = 4,
    parameter int H  = 8,
    parameter int XS = 4,
    parameter int YS = 5
) (
    input  logic [W*H-1:0]      board,
    input  logic [3:0]          mask,
    input  logic signed [XS-1:0] x,
    input  logic signed [YS-1:0] y,
    output logic                hit
);

    int cx;
    int cy;

    always_comb begin
        hit = 1'b0;
        cx  = 0;
        cy  = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                cx = int'(x) + (i % 2);
                cy = int'(y) + (i / 2);
                if (cx < 0 || cx >= W || cy < 0 || cy >= H) hit = 1'b1;
                // Constant-index scan keeps the board lookup free of variable selects
                for (int r = 0; r < H; r++) begin
                    for (int c = 0; c < W; c++) begin
                        if (cy == r && cx == c && board[r*W+c]) hit = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/board_engine.sv
// Playfield engine: locked board + one active piece, move/rotate/drop, gravity, lock, row clear.
// Latency: accepted command/tick visible next cycle; land-to-next-piece = 1 + BOARD_H + k + 1 cycles.
// Backpressure: cmd_ready only in ACTIVE without tick; tick wins and the command must be held.
// Ports: clka/restart (sync, active-high); start, tick, cmd_valid/cmd/cmd_ready, piece_in in;
//        board_out (row 0 top, bit y*W+x), piece_type/rot/x/y, touched, lines, busy, game_over out.
// Optional: BOARD_ENGINE_HARD_DROP_EN adds hard_drop input and a DROP state.
module board_engine
    import board_engine_pkg::*;
#(
    parameter int BOARD_W = 4,
    parameter int BOARD_H = 8,
    parameter int LINES_W = 16
) (
    input  logic                         clka,
    input  logic                         restart,
    input  logic                         start,
    input  logic                         tick,
    input  logic                         cmd_valid,
    input  logic [1:0]                   cmd,
    output logic                         cmd_ready,
`ifdef BOARD_ENGINE_HARD_DROP_EN
    input  logic                         hard_drop,
`endif
    input  logic [1:0]                   piece_in,
    output logic [BOARD_W*BOARD_H-1:0]   board_out,
    output logic [1:0]                   piece_type,
    output logic [1:0]                   piece_rot,
    output logic [$clog2(BOARD_W)-1:0]   piece_x,
    output logic [$clog2(BOARD_H)-1:0]   piece_y,
    output logic                         touched,
    output logic [LINES_W-1:0]           lines,
    output logic                         busy,
    output logic                         game_over
);

    localparam int N  = BOARD_W * BOARD_H;
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);
    // Two extra bits give candidates room for -1 and one-past-the-edge
    localparam int XS = XW + 2;
    localparam int YS = YW + 2;

    localparam logic [XW-1:0]        SPAWN_X  = XW'((BOARD_W - 2) / 2);
    localparam logic [YW-1:0]        ROW_LAST = YW'(BOARD_H - 1);
    localparam logic [XW-1:0]        X_STEP   = XW'(1);
    localparam logic [YW-1:0]        Y_STEP   = YW'(1);
    localparam logic [1:0]           ROT_STEP = 2'd1;
    localparam logic [LINES_W-1:0]   L_STEP   = LINES_W'(1);
    localparam logic signed [XS-1:0] X_ONE    = XS'(1);
    localparam logic signed [YS-1:0] Y_ONE    = YS'(1);

    state_t         state;
    logic [N-1:0]   board;
    logic [YW-1:0]  row_ptr;

    logic [3:0]             cur_mask, rot_mask, spawn_mask;
    logic signed [XS-1:0]   x_cur, move_x, spawn_x;
    logic signed [YS-1:0]   y_cur, down_y;
    logic                   move_hit, rot_hit, down_hit, spawn_hit;
    logic                   fall;
    logic [N-1:0]           piece_bits;
    logic [N-1:0]           keep_mask;
    logic [N-1:0]           shifted;
    logic [BOARD_H-1:0]     row_full;

    assign cur_mask   = piece_mask(piece_type, piece_rot);
    assign rot_mask   = piece_mask(piece_type, piece_rot + ROT_STEP);
    assign spawn_mask = piece_mask(piece_in, 2'd0);
    assign x_cur      = signed'({2'b00, piece_x});
    assign y_cur      = signed'({2'b00, piece_y});
    assign spawn_x    = signed'({2'b00, SPAWN_X});
    assign move_x     = (cmd == CMD_RIGHT) ? x_cur + X_ONE : x_cur - X_ONE;
    assign down_y     = y_cur + Y_ONE;
    assign fall       = tick | (cmd_valid & (cmd == CMD_DOWN));

    board_collide #(.W(BOARD_W), .H(BOARD_H), .XS(XS), .YS(YS)) u_move (
        .board(board), .mask(cur_mask), .x(move_x), .y(y_cur), .hit(move_hit));
    board_collide #(.W(BOARD_W), .H(BOARD_H), .XS(XS), .YS(YS)) u_rot (
        .board(board), .mask(rot_mask), .x(x_cur), .y(y_cur), .hit(rot_hit));
    board_collide #(.W(BOARD_W), .H(BOARD_H), .XS(XS), .YS(YS)) u_down (
        .board(board), .mask(cur_mask), .x(x_cur), .y(down_y), .hit(down_hit));
    board_collide #(.W(BOARD_W), .H(BOARD_H), .XS(XS), .YS(YS)) u_spawn (
        .board(board), .mask(spawn_mask), .x(spawn_x), .y('0), .hit(spawn_hit));

    // Active piece rendered as board bits
    always_comb begin
        piece_bits = '0;
        for (int r = 0; r < BOARD_H; r++) begin
            for (int c = 0; c < BOARD_W; c++) begin
                for (int i = 0; i < 4; i++) begin
                    if (cur_mask[i] && (int'(piece_x) + (i % 2)) == c &&
                        (int'(piece_y) + (i / 2)) == r)
                        piece_bits[r*BOARD_W+c] = 1'b1;
                end
            end
        end
    end

    // Row clear: rows above (and including) row_ptr take the row above them,
    // which is exactly board << W; rows below row_ptr are kept.
    always_comb begin
        keep_mask = '0;
        row_full  = '0;
        for (int r = 0; r < BOARD_H; r++) begin
            keep_mask[r*BOARD_W +: BOARD_W] = {BOARD_W{r > int'(row_ptr)}};
            row_full[r] = &board[r*BOARD_W +: BOARD_W];
        end
        shifted = (board & keep_mask) | ((board << BOARD_W) & ~keep_mask);
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state      <= S_IDLE;
            board      <= '0;
            lines      <= '0;
            piece_type <= '0;
            piece_rot  <= '0;
            piece_x    <= '0;
            piece_y    <= '0;
            touched    <= 1'b0;
            row_ptr    <= '0;
        end else begin
            touched <= 1'b0;
            case (state)
                S_IDLE: if (start) state <= S_SPAWN;
                S_SPAWN: begin
                    piece_type <= piece_in;
                    piece_rot  <= '0;
                    piece_x    <= SPAWN_X;
                    piece_y    <= '0;
                    state      <= spawn_hit ? S_GAMEOVER : S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (fall) begin
                        if (down_hit) begin
                            state   <= S_LAND;
                            touched <= 1'b1;
                        end else begin
                            piece_y <= piece_y + Y_STEP;
                        end
                    end else if (cmd_valid) begin
                        case (cmd)
                            CMD_LEFT, CMD_RIGHT:
                                if (!move_hit)
                                    piece_x <= (cmd == CMD_RIGHT) ? piece_x + X_STEP
                                                                  : piece_x - X_STEP;
                            CMD_ROTATE:
                                if (!rot_hit) piece_rot <= piece_rot + ROT_STEP;
                            default: ;
                        endcase
                    end
`ifdef BOARD_ENGINE_HARD_DROP_EN
                    else if (hard_drop) begin
                        state <= S_DROP;
                    end
`endif
                end
`ifdef BOARD_ENGINE_HARD_DROP_EN
                S_DROP: begin
                    if (down_hit) begin
                        state   <= S_LAND;
                        touched <= 1'b1;
                    end else begin
                        piece_y <= piece_y + Y_STEP;
                    end
                end
`endif
                S_LAND: begin
                    board   <= board | piece_bits;
                    row_ptr <= ROW_LAST;
                    state   <= S_CLEAR;
                end
                S_CLEAR: begin
                    // A full row is re-examined after the shift since a new row dropped into it
                    if (row_full[row_ptr]) begin
                        board <= shifted;
                        if (lines != {LINES_W{1'b1}}) lines <= lines + L_STEP;
                    end else if (row_ptr == '0) begin
                        state <= S_SPAWN;
                    end else begin
                        row_ptr <= row_ptr - Y_STEP;
                    end
                end
                S_GAMEOVER: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_GAMEOVER: board_out = '1;
            S_ACTIVE, S_LAND: board_out = board | piece_bits;
`ifdef BOARD_ENGINE_HARD_DROP_EN
            S_DROP: board_out = board | piece_bits;
`endif
            default: board_out = board;
        endcase
    end

    assign cmd_ready = (state == S_ACTIVE) && !tick;
    assign busy      = (state == S_LAND) || (state == S_CLEAR);
    assign game_over = (state == S_GAMEOVER);

endmodule

// File: tb/tb_board_engine.sv
module tb_board_engine;

    logic        clka = 1'b0;
    logic        restart, start, tick, cmd_valid;
    logic [1:0]  cmd, piece_in;
`ifdef BOARD_ENGINE_HARD_DROP_EN
    logic        hard_drop = 1'b0;
`endif
    logic        cmd_ready, touched, busy, game_over;
    logic [31:0] board_out;
    logic [1:0]  piece_type, piece_rot;
    logic [1:0]  piece_x;
    logic [2:0]  piece_y;
    logic [15:0] lines;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] LEFT = 2'd0, RIGHT = 2'd1, ROT = 2'd2;

    board_engine #(.BOARD_W(4), .BOARD_H(8), .LINES_W(16)) dut (
        .clka(clka), .restart(restart), .start(start), .tick(tick),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
`ifdef BOARD_ENGINE_HARD_DROP_EN
        .hard_drop(hard_drop),
`endif
        .piece_in(piece_in), .board_out(board_out), .piece_type(piece_type),
        .piece_rot(piece_rot), .piece_x(piece_x), .piece_y(piece_y),
        .touched(touched), .lines(lines), .busy(busy), .game_over(game_over));

    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        step();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic tick_n(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
        #1;
    endtask

    task automatic drop_piece(input int exp_ticks);
        int cnt = 0;
        tick = 1'b1;
        while (touched !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        tick = 1'b0;
        #1;
        chk("drop_ticks", cnt, exp_ticks);
    endtask

    task automatic wait_settle();
        int cnt = 0;
        while (cmd_ready !== 1'b1 && game_over !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk("settle_in_bound", cnt < 40, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_board"}, board_out, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_touched"}, touched, 0);
        chk({tag, "_lines"}, lines, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_piece"}, {piece_type, piece_rot, piece_x, piece_y}, 0);
    endtask

    initial begin
        restart = 1'b1; start = 1'b0; tick = 1'b0;
        cmd_valid = 1'b0; cmd = 2'd0; piece_in = 2'd0;
        repeat (2) step();
        restart = 1'b0;
        #1;
        chk_reset_outputs("reset");

        // Spawn a 2x2 block: x=1, y=0, cells 1,2,5,6
        piece_in = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("spawn_type", piece_type, 3);
        chk("spawn_x", piece_x, 1);
        chk("spawn_y", piece_y, 0);
        chk("spawn_board", board_out, 32'h0000_0066);
        chk("spawn_ready", cmd_ready, 1);

        // Wall limits
        do_cmd(LEFT);
        chk("left1_x", piece_x, 0);
        do_cmd(LEFT);
        do_cmd(LEFT);
        chk("left3_x", piece_x, 0);
        do_cmd(RIGHT);
        chk("right1_x", piece_x, 1);
        repeat (4) do_cmd(RIGHT);
        chk("right5_x", piece_x, 2);
        chk("right5_board", board_out, 32'h0000_00CC);

        // tick beats command; held command accepted a cycle later
        tick = 1'b1; cmd_valid = 1'b1; cmd = LEFT;
        #1;
        chk("tick_cmd_ready", cmd_ready, 0);
        step();
        tick = 1'b0;
        #1;
        chk("tick_y", piece_y, 1);
        chk("tick_x_unchanged", piece_x, 2);
        chk("held_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("held_cmd_x", piece_x, 1);

        // Fall to floor and lock; no full rows
        tick_n(5);
        chk("floor_y", piece_y, 6);
        tick_n(1);
        chk("lock_touched", touched, 1);
        chk("lock_busy", busy, 1);
        chk("lock_board", board_out, 32'h6600_0000);
        piece_in = 2'd0;
        step();
        chk("touched_pulse_end", touched, 0);
        chk("clear_busy", busy, 1);
        repeat (7) step();
        chk("clear_last_row_busy", busy, 1);
        step();
        chk("respawn_busy", busy, 0);
        chk("respawn_ready", cmd_ready, 0);
        step();
        chk("next_ready", cmd_ready, 1);
        chk("next_type", piece_type, 0);
        chk("next_board", board_out, 32'h6600_0002);

        restart = 1'b1;
        step();
        restart = 1'b0;
        #1;
        chk("restart_board", board_out, 0);
        chk("restart_ready", cmd_ready, 0);

        // Build rows 6-7 with cols 0 and 3 filled using vertical dominoes
        piece_in = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t1_board", board_out, 32'h0000_0006);
        do_cmd(ROT);
        chk("t1_rot", piece_rot, 1);
        chk("t1_rot_board", board_out, 32'h0000_0044);
        do_cmd(RIGHT);
        chk("t1_right_board", board_out, 32'h0000_0088);
        tick_n(7);
        chk("t1_lock", touched, 1);
        chk("t1_lock_board", board_out, 32'h8800_0000);
        repeat (10) step();
        chk("t1b_ready", cmd_ready, 1);
        chk("t1b_board", board_out, 32'h8800_0006);
        repeat (3) do_cmd(ROT);
        chk("t1b_rot", piece_rot, 3);
        chk("t1b_rot_board", board_out, 32'h8800_0022);
        do_cmd(LEFT);
        chk("t1b_x", piece_x, 0);
        chk("t1b_left_board", board_out, 32'h8800_0011);
        piece_in = 2'd3;
        tick_n(7);
        chk("t1b_lock_board", board_out, 32'h9900_0000);
        repeat (10) step();
        chk("t3_board", board_out, 32'h9900_0066);

        // Block completes rows 6 and 7
        tick_n(7);
        chk("full_lock", touched, 1);
        chk("full_lock_board", board_out, 32'hFF00_0000);
        step();
        chk("clr0_lines", lines, 0);
        chk("clr0_board", board_out, 32'hFF00_0000);
        step();
        chk("clr1_lines", lines, 1);
        chk("clr1_board", board_out, 32'hF000_0000);
        step();
        chk("clr2_lines", lines, 2);
        chk("clr2_board", board_out, 0);
        repeat (8) step();
        chk("clr_spawn_busy", busy, 0);
        step();
        chk("clr_next_ready", cmd_ready, 1);
        chk("clr_next_lines", lines, 2);
        chk("clr_next_board", board_out, 32'h0000_0066);

        // restart in the middle of CLEAR
        tick_n(7);
        chk("mid_lock", touched, 1);
        step();
        step();
        chk("mid_busy", busy, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        #1;
        chk("mid_restart_board", board_out, 0);
        chk("mid_restart_lines", lines, 0);
        chk("mid_restart_busy", busy, 0);

        // Stack blocks until spawn collides
        piece_in = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        drop_piece(7);
        wait_settle();
        chk("stack1_ready", cmd_ready, 1);
        drop_piece(5);
        wait_settle();
        chk("stack2_ready", cmd_ready, 1);
        drop_piece(3);
        wait_settle();
        chk("stack3_ready", cmd_ready, 1);
        drop_piece(1);
        wait_settle();
        chk("go_flag", game_over, 1);
        chk("go_board", board_out, 32'hFFFF_FFFF);
        chk("go_ready", cmd_ready, 0);
        chk("go_busy", busy, 0);
        tick_n(2);
        chk("go_sticky", game_over, 1);

        restart = 1'b1;
        step();
        restart = 1'b0;
        #1;
        chk_reset_outputs("go_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
